main_fsm: RTL and testbench

- Moore control state machine for the multicycle RV32I datapath. Sits directly upstream of ALU_Decoder and produces its ALUOp input.
- Sequences fetch/decode/execute/writeback for lw, sw, R-type, I-type ALU, beq and jal.
- Drives all datapath enables and mux selects.
- Stalls on a memory-ready handshake.

---
 rtl/main_fsm_pkg.sv | 66 ++++++
 rtl/main_fsm_if.sv | 32 +++
 rtl/main_fsm.sv | 128 ++++++++++++
 tb/tb_main_fsm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/main_fsm_pkg.sv
// Shared constants for the multicycle RV32I control path: state codes, opcodes,
// ALUOp and mux-select encodings, and the packed control word.
package ctrl_pkg;

    localparam int OPW  = 7;
    localparam int SW_W = 4;

    localparam logic [SW_W-1:0] S_FETCH    = 4'd0;
    localparam logic [SW_W-1:0] S_DECODE   = 4'd1;
    localparam logic [SW_W-1:0] S_MEMADR   = 4'd2;
    localparam logic [SW_W-1:0] S_MEMREAD  = 4'd3;
    localparam logic [SW_W-1:0] S_MEMWB    = 4'd4;
    localparam logic [SW_W-1:0] S_MEMWRITE = 4'd5;
    localparam logic [SW_W-1:0] S_EXECUTER = 4'd6;
    localparam logic [SW_W-1:0] S_EXECUTEI = 4'd7;
    localparam logic [SW_W-1:0] S_ALUWB    = 4'd8;
    localparam logic [SW_W-1:0] S_BEQ      = 4'd9;
    localparam logic [SW_W-1:0] S_JAL      = 4'd10;

    localparam logic [OPW-1:0] OP_LW  = 7'b0000011;
    localparam logic [OPW-1:0] OP_SW  = 7'b0100011;
    localparam logic [OPW-1:0] OP_R   = 7'b0110011;
    localparam logic [OPW-1:0] OP_I   = 7'b0010011;
    localparam logic [OPW-1:0] OP_BEQ = 7'b1100011;
    localparam logic [OPW-1:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic op_supported(logic [OPW-1:0] op);
        logic ok;
        case (op)
            OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL: ok = 1'b1;
            default:                                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/main_fsm_if.sv
// Control bundle between main_fsm (master) and the multicycle datapath (slave).
interface main_fsm_if;
    import ctrl_pkg::*;

    logic [OPW-1:0]  op;
    logic            zero;
    logic            mem_ready;
    logic            PCWrite;
    logic            AdrSrc;
    logic            MemWrite;
    logic            IRWrite;
    logic            RegWrite;
    logic [1:0]      ResultSrc;
    logic [1:0]      ALUSrcA;
    logic [1:0]      ALUSrcB;
    logic [1:0]      ALUOp;
    logic            illegal_op;
    logic [SW_W-1:0] state_dbg;

    modport master (
        input  op, zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op, state_dbg
    );

    modport slave (
        output op, zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp, illegal_op, state_dbg
    );

endinterface

// File: rtl/main_fsm.sv
// Moore sequencer for the multicycle RV32I datapath (lw, sw, R, I, beq, jal).
// state    | meaning
// FETCH    | read instr at PC, PC += 4, wait for mem_ready
// DECODE   | compute PC+imm, dispatch on opcode
// MEMADR   | rs1 + imm address
// MEMREAD  | load data, wait for mem_ready
// MEMWB    | write loaded data to rd
// MEMWRITE | store strobe, wait for mem_ready
// EXECUTER | rs1 op rs2
// EXECUTEI | rs1 op imm
// ALUWB    | write ALU result to rd
// BEQ      | compare, PC <= target if zero
// JAL      | PC <= target, rd link via ALUWB
module main_fsm
    import ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    main_fsm_if.master bus
);

    logic [SW_W-1:0] state_q, state_d;
    ctrl_t           c;

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = bus.mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_comb begin
        c = '0;
        case (state_q)
            S_FETCH: begin
                c.alu_src_b  = SRCB_FOUR;
                c.result_src = RES_ALU;
                c.ir_write   = bus.mem_ready;
                c.pc_update  = bus.mem_ready;
            end
            S_DECODE: begin
                c.alu_src_a  = SRCA_OLDPC;
                c.alu_src_b  = SRCB_IMM;
                c.illegal_op = ~op_supported(bus.op);
            end
            S_MEMADR: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD:  c.adr_src = 1'b1;
            S_MEMWB: begin
                c.result_src = RES_DATA;
                c.reg_write  = 1'b1;
            end
            S_MEMWRITE: begin
                c.adr_src   = 1'b1;
                c.mem_write = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_IMM;
                c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB:    c.reg_write = 1'b1;
            S_BEQ: begin
                c.alu_src_a = SRCA_RD1;
                c.alu_src_b = SRCB_RD2;
                c.alu_op    = ALUOP_SUB;
                c.branch    = 1'b1;
            end
            S_JAL: begin
                c.alu_src_a = SRCA_OLDPC;
                c.alu_src_b = SRCB_FOUR;
                c.pc_update = 1'b1;
            end
            default: c = '0;
        endcase
        // Reset presents FETCH selects with every strobe suppressed
        if (reset) begin
            c            = '0;
            c.alu_src_b  = SRCB_FOUR;
            c.result_src = RES_ALU;
        end
    end

    assign bus.PCWrite    = c.pc_update | (c.branch & bus.zero);
    assign bus.AdrSrc     = c.adr_src;
    assign bus.MemWrite   = c.mem_write;
    assign bus.IRWrite    = c.ir_write;
    assign bus.RegWrite   = c.reg_write;
    assign bus.ResultSrc  = c.result_src;
    assign bus.ALUSrcA    = c.alu_src_a;
    assign bus.ALUSrcB    = c.alu_src_b;
    assign bus.ALUOp      = c.alu_op;
    assign bus.illegal_op = c.illegal_op;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_main_fsm.sv
// Scoreboard bench for main_fsm: instruction-level model expands each instruction
// into its per-cycle state walk and expected control word; a monitor compares.
module tb_main_fsm;

    localparam int T_FETCH = 0, T_DECODE = 1, T_MEMADR = 2, T_MEMREAD = 3, T_MEMWB = 4;
    localparam int T_MEMWRITE = 5, T_EXECR = 6, T_EXECI = 7, T_ALUWB = 8, T_BEQ = 9, T_JAL = 10;
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_JAL = 5, K_ILL = 6;

    typedef struct {
        logic [3:0]  st;
        logic [13:0] ctrl;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    main_fsm_if bus();

    main_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic int kind_of(logic [6:0] op);
        case (op)
            7'b0000011: return K_LW;
            7'b0100011: return K_SW;
            7'b0110011: return K_R;
            7'b0010011: return K_I;
            7'b1100011: return K_BEQ;
            7'b1101111: return K_JAL;
            default:    return K_ILL;
        endcase
    endfunction

    // Control word order: PCWrite AdrSrc MemWrite IRWrite RegWrite ResultSrc ALUSrcA ALUSrcB ALUOp illegal_op
    function automatic logic [13:0] exp_ctrl(int st, bit rst, logic [6:0] op, bit z, bit mr);
        logic       pcw = 0, adr = 0, mw = 0, irw = 0, rw = 0, ill = 0;
        logic [1:0] res = 0, a = 0, b = 0, aop = 0;
        if (rst) begin
            b = 2'b10; res = 2'b10;
        end else begin
            case (st)
                T_FETCH:    begin b = 2'b10; res = 2'b10; irw = mr; pcw = mr; end
                T_DECODE:   begin a = 2'b01; b = 2'b01; ill = (kind_of(op) == K_ILL); end
                T_MEMADR:   begin a = 2'b10; b = 2'b01; end
                T_MEMREAD:  adr = 1;
                T_MEMWB:    begin res = 2'b01; rw = 1; end
                T_MEMWRITE: begin adr = 1; mw = 1; end
                T_EXECR:    begin a = 2'b10; b = 2'b00; aop = 2'b10; end
                T_EXECI:    begin a = 2'b10; b = 2'b01; aop = 2'b10; end
                T_ALUWB:    rw = 1;
                T_BEQ:      begin a = 2'b10; aop = 2'b01; pcw = z; end
                T_JAL:      begin a = 2'b01; b = 2'b10; pcw = 1; end
                default:    ;
            endcase
        end
        return {pcw, adr, mw, irw, rw, res, a, b, aop, ill};
    endfunction

    task automatic drive_cycle(int st, bit rst, logic [6:0] op, bit z, bit mr);
        exp_t e;
        reset         = rst;
        bus.op        = op;
        bus.zero      = z;
        bus.mem_ready = mr;
        e.st   = 4'(st);
        e.ctrl = exp_ctrl(st, rst, op, z, mr);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // zval < 0 randomises zero each cycle; abort_at indexes the cycle that gets reset
    task automatic run_instr(logic [6:0] op, int zval, int fstall, int mstall, int abort_at);
        int st_q[$];
        bit mr_q[$];
        int k = kind_of(op);
        bit z;
        for (int i = 0; i < fstall; i++) begin st_q.push_back(T_FETCH); mr_q.push_back(0); end
        st_q.push_back(T_FETCH);  mr_q.push_back(1);
        st_q.push_back(T_DECODE); mr_q.push_back(1'($urandom_range(0, 1)));
        case (k)
            K_LW: begin
                st_q.push_back(T_MEMADR); mr_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mstall; i++) begin st_q.push_back(T_MEMREAD); mr_q.push_back(0); end
                st_q.push_back(T_MEMREAD); mr_q.push_back(1);
                st_q.push_back(T_MEMWB);   mr_q.push_back(1'($urandom_range(0, 1)));
            end
            K_SW: begin
                st_q.push_back(T_MEMADR); mr_q.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < mstall; i++) begin st_q.push_back(T_MEMWRITE); mr_q.push_back(0); end
                st_q.push_back(T_MEMWRITE); mr_q.push_back(1);
            end
            K_R: begin
                st_q.push_back(T_EXECR); mr_q.push_back(1'($urandom_range(0, 1)));
                st_q.push_back(T_ALUWB); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            K_I: begin
                st_q.push_back(T_EXECI); mr_q.push_back(1'($urandom_range(0, 1)));
                st_q.push_back(T_ALUWB); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            K_BEQ: begin
                st_q.push_back(T_BEQ); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            K_JAL: begin
                st_q.push_back(T_JAL);   mr_q.push_back(1'($urandom_range(0, 1)));
                st_q.push_back(T_ALUWB); mr_q.push_back(1'($urandom_range(0, 1)));
            end
            default: ;
        endcase
        for (int i = 0; i < st_q.size(); i++) begin
            z = (zval < 0) ? 1'($urandom_range(0, 1)) : 1'(zval);
            drive_cycle(st_q[i], (i == abort_at), op, z, mr_q[i]);
            if (i == abort_at) break;
        end
    endtask

    initial begin : monitor
        exp_t        e;
        logic [13:0] act;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e   = sb_q.pop_front();
                act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                       bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.illegal_op};
                n_checks++;
                if (bus.state_dbg !== e.st) begin
                    n_fail++;
                    $display("FAIL state t=%0t got=%0d exp=%0d", $time, bus.state_dbg, e.st);
                end
                n_checks++;
                if (act !== e.ctrl) begin
                    n_fail++;
                    $display("FAIL ctrl t=%0t state=%0d got=%b exp=%b", $time, e.st, act, e.ctrl);
                end
            end
        end
    end

    initial begin : stim
        logic [6:0] ops[6];
        logic [6:0] op;
        int         ab;
        ops[0] = 7'b0000011; ops[1] = 7'b0100011; ops[2] = 7'b0110011;
        ops[3] = 7'b0010011; ops[4] = 7'b1100011; ops[5] = 7'b1101111;

        reset = 1'b1; bus.op = 7'b0110011; bus.zero = 1'b0; bus.mem_ready = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(T_FETCH, 1, 7'b0110011, 0, 1);
        drive_cycle(T_FETCH, 1, 7'b0110011, 0, 1);

        run_instr(7'b0000011, 0, 0, 0, 1000);
        run_instr(7'b0100011, 0, 0, 2, 1000);
        run_instr(7'b0110011, 0, 0, 0, 1000);
        run_instr(7'b0010011, 0, 0, 0, 1000);
        run_instr(7'b1100011, 1, 0, 0, 1000);
        run_instr(7'b1100011, 0, 0, 0, 1000);
        run_instr(7'b1101111, 0, 0, 0, 1000);
        run_instr(7'b1111111, 0, 0, 0, 1000);
        run_instr(7'b0110011, 0, 3, 0, 1);
        run_instr(7'b0000011, 0, 0, 0, 1000);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) < 6) op = ops[$urandom_range(0, 5)];
            else                          op = 7'($urandom_range(0, 127));
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 6) : 1000;
            run_instr(op, -1, $urandom_range(0, 2), $urandom_range(0, 3), ab);
        end

        repeat (3) @(posedge clk);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain got=%0d pending exp=0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
